// File: rtl/lsu_ctrl.sv
// Load/store unit: computes the effective address, checks legality, drives dMEM for one cycle and
// returns load data or a precise exception. Stalls the core via lsu_busy while an op is in flight.
module lsu_ctrl #(
    parameter int unsigned DMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    output logic        lsu_busy,
    output logic        mem_write_en,
    output logic [2:0]  s_type,
    output logic [2:0]  l_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        op_done,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output logic [31:0] exc_addr
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp, StFault} state_e;

    localparam logic [31:0] AddrLimit = 32'(4 * DMEM_WORDS);
    localparam logic [2:0]  TypeIdle  = 3'b010;

    state_e      state_q;
    logic        is_store_q;
    logic        mem_we_q;
    logic [4:0]  rd_q;

    logic [31:0] eff_addr;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [3:0]  cause;

    always_comb begin
        eff_addr = ex_rs1 + ex_imm;
        if (ex_is_store) begin
            illegal = ex_funct3[2] | (ex_funct3[1:0] == 2'b11);
        end else begin
            illegal = (ex_funct3[1:0] == 2'b11) | (ex_funct3 == 3'b110);
        end
        misaligned   = ((ex_funct3[1:0] == 2'b01) & eff_addr[0]) |
                       ((ex_funct3[1:0] == 2'b10) & (eff_addr[1:0] != 2'b00));
        out_of_range = (eff_addr >= AddrLimit);
        cause = 4'd0;
        if (illegal) begin
            cause = 4'd2;
        end else if (misaligned) begin
            cause = ex_is_store ? 4'd6 : 4'd4;
        end else if (out_of_range) begin
            cause = ex_is_store ? 4'd7 : 4'd5;
        end
    end

    // Gated combinationally so a reset landing in ACCESS can never commit a store.
    assign mem_write_en = mem_we_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            mem_we_q   <= 1'b0;
            rd_q       <= 5'd0;
            lsu_busy   <= 1'b0;
            s_type     <= TypeIdle;
            l_type     <= TypeIdle;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            op_done    <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            exc_valid  <= 1'b0;
            exc_cause  <= 4'd0;
            exc_addr   <= 32'd0;
        end else begin
            op_done   <= 1'b0;
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            s_type    <= TypeIdle;
            l_type    <= TypeIdle;
            unique case (state_q)
                StIdle: begin
                    if (ex_valid) begin
                        is_store_q <= ex_is_store;
                        rd_q       <= ex_rd;
                        lsu_busy   <= 1'b1;
                        if (cause != 4'd0) begin
                            state_q   <= StFault;
                            exc_valid <= 1'b1;
                            exc_cause <= cause;
                            exc_addr  <= (cause == 4'd2) ? 32'd0 : eff_addr;
                        end else begin
                            state_q   <= StAccess;
                            mem_we_q  <= ex_is_store;
                            mem_addr  <= eff_addr;
                            mem_wdata <= ex_rs2;
                            s_type    <= ex_funct3;
                            l_type    <= ex_funct3;
                        end
                    end
                end
                StAccess: begin
                    state_q <= StResp;
                    op_done <= 1'b1;
                    if (!is_store_q) begin
                        wb_data <= mem_rdata;
                        if (rd_q != 5'd0) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                        end
                    end
                end
                StResp: begin
                    state_q  <= StIdle;
                    lsu_busy <= 1'b0;
                end
                StFault: begin
                    state_q  <= StIdle;
                    lsu_busy <= 1'b0;
                end
                default: begin
                    state_q  <= StIdle;
                    lsu_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
